sm_seq_decoder: RTL and testbench
=================================

# sm_seq_decoder

Receive-side decoder for the 2-bit four-state sequence stream (`0→1→{2|3}→3→0`) produced by the team's state-machine sequencer. It samples the `y` stream and checks every transition against the legal set. From each branch taken out of state 1 it recovers the sequencer's `control` decision. It reports loss of sequence with a lock flag and a saturating error counter, and sits at the consuming end of any link carrying sequencer output.

## Interface
- `LOCK_PERIODS`, default 2: consecutive legal complete periods (each ending in a `3→0` transition) required to declare lock. Must be ≥1.
- `ERR_CNT_WIDTH`, default 8: width of the error counter.

Ports:
- `clk` in 1: the single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `y_in` in 2: sequencer state sample.
- `y_valid` in 1: `y_in` is a valid sample this cycle. Consecutive valid samples are consecutive sequencer states.
- `err_clr` in 1: synchronous clear of `err_count`.
- `ctrl_out` out 1: recovered control bit. Holds its value between decodes.
- `ctrl_valid` out 1: one-cycle pulse; `ctrl_out` has been updated.
- `locked` out 1: decoder is tracking a legal sequence.
- `err_pulse` out 1: one-cycle pulse; an illegal transition was seen while locked.
- `err_count` out `ERR_CNT_WIDTH`: saturating count of locked-state errors.

## Operation
- Legal transitions (previous valid sample → current valid sample): `0→1`, `1→2`, `1→3`, `2→3`, `3→0`. Every other pair is illegal, including repeats such as `1→1`.
- Internal state:
  - `prev` (2 bits) and `have_prev` flag.
  - `period_cnt`, sized to hold `LOCK_PERIODS`.
  - FSM with states `HUNT` and `LOCKED`.
- Only cycles with `y_valid=1` update the internal state. With `y_valid=0`, all internal state holds and both pulses are 0.
- The first valid sample after reset loads `prev`, sets `have_prev`, and performs no transition check.
- Every later valid sample loads `prev` after it is evaluated, whether the transition was legal or not.
- `HUNT` behaviour:
  - A legal `3→0` increments `period_cnt`.
  - If the incremented value equals `LOCK_PERIODS`, go to `LOCKED` and clear `period_cnt`.
  - An illegal transition clears `period_cnt`.
  - No `ctrl_valid` and no `err_pulse` are generated in `HUNT`.
- `LOCKED` behaviour:
  - Legal `1→3`: `ctrl_out←1`, `ctrl_valid` pulses.
  - Legal `1→2`: `ctrl_out←0`, `ctrl_valid` pulses.
  - Other legal transitions produce no output event.
  - Illegal transition: `err_pulse` pulses, `err_count` increments (saturates at all-ones), go to `HUNT`, `period_cnt←0`. The offending sample becomes `prev`, and hunting restarts from it.
- `err_clr=1` sets `err_count←0`. If an error occurs in the same cycle, the result is `err_count=1`; clear applies first, then the increment.
- `err_count` saturation: once all-ones, further errors still pulse `err_pulse`, but the count stays unchanged.

## Timing
- All outputs are registered. Latency is 1 clock from the sampling edge of the decisive valid sample to the update of `ctrl_out`/`ctrl_valid`, `err_pulse`/`err_count`, or `locked`.
- `locked` rises in the cycle after the valid `0` sample that completes the `LOCK_PERIODS`-th period. It falls in the same cycle that `err_pulse` is 1.
- The first decode possible after lock is the next `1→{2,3}` transition.
- Reset values, applied asynchronously and released on the next edge:
  - `ctrl_out=0`, `ctrl_valid=0`, `locked=0`, `err_pulse=0`, `err_count=0`.
  - Internal: `prev=0`, `have_prev=0`, `period_cnt=0`, FSM in `HUNT`.
- Reset mid-stream discards all history. The next valid sample is treated as the first sample after reset.
- `ctrl_valid` and `err_pulse` are never both 1 in the same cycle.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle while `locked=1` and `err_count=5` → all outputs become 0 immediately, with no clock edge required. After release, the first valid sample raises no error.
- **Lock and decode:** `LOCK_PERIODS=2`; valid stream `0,1,3,0,1,2,3,0` → `locked=1` the cycle after the final `0`. Then feed `1,3` → `ctrl_out=1` and `ctrl_valid` pulses once. Then feed `0,1,2` → `ctrl_out=0` and `ctrl_valid` pulses once.
- **Error:** while locked, after sample `0` feed `2` → `err_pulse=1`, `err_count=1`, `locked=0` on the next cycle. Then feed `3,0,1,3,0` → `locked=1` after the second `0`, with no `ctrl_valid` during the hunt.
- **Valid gaps:** locked; feed `1`, then hold `y_valid=0` for 3 cycles with `y_in=2` (garbage), then feed `3` → `ctrl_out=1`, one `ctrl_valid`, no error.
- **Saturation and clear:** `ERR_CNT_WIDTH=2`; force 4 locked errors, relocking between each → `err_count` reads 3 after both the 3rd and 4th errors, and `err_pulse` still fires on the 4th. Then assert `err_clr` in the same cycle as a 5th error → `err_count=1`.
- **Hunt silence:** while in `HUNT`, feed illegal pairs `0→0` and `2→1` → no `err_pulse` and `err_count` unchanged. `period_cnt` resets, and lock therefore needs 2 fresh complete periods.

Source files
------------

// File: rtl/sm_seq_decoder.sv
// sm_seq_decoder
// Receive-side decoder for the four-state sequencer stream 0->1->{2|3}->3->0.
// Every transition between consecutive valid samples is checked against the
// legal set. Once enough clean periods have been seen the decoder declares
// lock, recovers the sequencer's control decision from each branch taken out
// of state 1, and reports illegal transitions through a pulse and a
// saturating counter.
//
// Ports:
//   clk        in  1              rising-edge clock
//   reset      in  1              asynchronous active-high reset
//   y_in       in  2              sequencer state sample
//   y_valid    in  1              y_in carries a valid sample this cycle
//   err_clr    in  1              synchronous clear of err_count
//   ctrl_out   out 1              recovered control bit, held between decodes
//   ctrl_valid out 1              one-cycle pulse, ctrl_out was just updated
//   locked     out 1              decoder is tracking a legal sequence
//   err_pulse  out 1              one-cycle pulse, illegal transition while locked
//   err_count  out ERR_CNT_WIDTH  saturating count of locked-state errors
module sm_seq_decoder #(
  parameter int LOCK_PERIODS  = 2,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               y_in,
  input  logic                     y_valid,
  input  logic                     err_clr,
  output logic                     ctrl_out,
  output logic                     ctrl_valid,
  output logic                     locked,
  output logic                     err_pulse,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  // Period counter must be able to hold the value LOCK_PERIODS itself, since
  // the incremented value is compared against it before being cleared.
  localparam int PW = (LOCK_PERIODS < 2) ? 1 : $clog2(LOCK_PERIODS + 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [1:0]               prev_q, prev_d;
  logic                     havePrev_q, havePrev_d;
  logic [PW-1:0]            periodCnt_q, periodCnt_d;
  logic                     ctrlOut_q, ctrlOut_d;
  logic                     ctrlValid_q, ctrlValid_d;
  logic                     errPulse_q, errPulse_d;
  logic [ERR_CNT_WIDTH-1:0] errCount_q, errCount_d;

  logic          checkEn;
  logic          legal;
  logic          periodEnd;
  logic          branchOut;
  logic [PW-1:0] periodInc;

  // A transition is only evaluated on a valid sample that has a predecessor;
  // the very first sample after reset just seeds prev.
  assign checkEn   = y_valid && havePrev_q;
  assign periodEnd = (prev_q == 2'd3) && (y_in == 2'd0);
  assign branchOut = (prev_q == 2'd1) && (y_in[1] == 1'b1);
  assign periodInc = periodCnt_q + PW'(1);

  // Legal-transition table for the previous/current sample pair.
  always_comb begin
    legal = 1'b0;
    case ({prev_q, y_in})
      4'b00_01, 4'b01_10, 4'b01_11, 4'b10_11, 4'b11_00: legal = 1'b1;
      default:                                          legal = 1'b0;
    endcase
  end

  // State register: all decoder state plus the registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      prev_q      <= 2'd0;
      havePrev_q  <= 1'b0;
      periodCnt_q <= '0;
      ctrlOut_q   <= 1'b0;
      ctrlValid_q <= 1'b0;
      errPulse_q  <= 1'b0;
      errCount_q  <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      havePrev_q  <= havePrev_d;
      periodCnt_q <= periodCnt_d;
      ctrlOut_q   <= ctrlOut_d;
      ctrlValid_q <= ctrlValid_d;
      errPulse_q  <= errPulse_d;
      errCount_q  <= errCount_d;
    end
  end

  // Next-state logic: hunting counts clean periods, locked drops back to
  // hunting on any illegal pair. The offending sample always becomes prev,
  // so a new hunt starts from it rather than from the last good state.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    havePrev_d  = havePrev_q;
    periodCnt_d = periodCnt_q;
    if (y_valid) begin
      prev_d     = y_in;
      havePrev_d = 1'b1;
    end
    if (checkEn) begin
      case (state_q)
        HUNT: begin
          if (!legal) begin
            periodCnt_d = '0;
          end else if (periodEnd) begin
            if (periodInc == PW'(LOCK_PERIODS)) begin
              state_d     = LOCKED;
              periodCnt_d = '0;
            end else begin
              periodCnt_d = periodInc;
            end
          end
        end
        LOCKED: begin
          if (!legal) begin
            state_d     = HUNT;
            periodCnt_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Output logic: decodes and errors only exist while locked. The clear is
  // applied before the error increment so a same-cycle error reads back as 1.
  always_comb begin
    ctrlOut_d   = ctrlOut_q;
    ctrlValid_d = 1'b0;
    errPulse_d  = 1'b0;
    errCount_d  = err_clr ? '0 : errCount_q;
    if (checkEn && (state_q == LOCKED)) begin
      if (!legal) begin
        errPulse_d = 1'b1;
        if (errCount_d != '1) begin
          errCount_d = errCount_d + ERR_CNT_WIDTH'(1);
        end
      end else if (branchOut) begin
        ctrlOut_d   = y_in[0];
        ctrlValid_d = 1'b1;
      end
    end
  end

  assign ctrl_out   = ctrlOut_q;
  assign ctrl_valid = ctrlValid_q;
  assign locked     = (state_q == LOCKED);
  assign err_pulse  = errPulse_q;
  assign err_count  = errCount_q;

endmodule

// File: tb/tb_sm_seq_decoder.sv
// Testbench for sm_seq_decoder. Two instances share one stimulus stream:
// the default configuration and one with a 2-bit error counter so that
// saturation can be observed alongside the wide count.
module tb_sm_seq_decoder;

  typedef struct {
    logic [1:0]  y;
    logic        v;
    logic        clr;
    logic [13:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] yIn;
  logic       yValid;
  logic       errClr;

  logic       ctrlOut, ctrlValid, locked, errPulse;
  logic [7:0] errCount;
  logic       satCtrlOut, satCtrlValid, satLocked, satErrPulse;
  logic [1:0] satErrCount;

  int total = 0;
  int bad   = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  sm_seq_decoder #(.LOCK_PERIODS(2), .ERR_CNT_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .y_in       (yIn),
    .y_valid    (yValid),
    .err_clr    (errClr),
    .ctrl_out   (ctrlOut),
    .ctrl_valid (ctrlValid),
    .locked     (locked),
    .err_pulse  (errPulse),
    .err_count  (errCount)
  );

  sm_seq_decoder #(.LOCK_PERIODS(2), .ERR_CNT_WIDTH(2)) dutSat (
    .clk        (clk),
    .reset      (reset),
    .y_in       (yIn),
    .y_valid    (yValid),
    .err_clr    (errClr),
    .ctrl_out   (satCtrlOut),
    .ctrl_valid (satCtrlValid),
    .locked     (satLocked),
    .err_pulse  (satErrPulse),
    .err_count  (satErrCount)
  );

  // Expected record layout: {ctrl, ctrlValid, locked, errPulse, cnt[7:0], satCnt[1:0]}
  task automatic addVec(input logic [1:0] y, input logic v, input logic clr,
                        input logic ctrl, input logic cv, input logic lk,
                        input logic ep, input logic [7:0] cnt, input logic [1:0] scnt);
    vec_t r;
    r.y   = y;
    r.v   = v;
    r.clr = clr;
    r.exp = {ctrl, cv, lk, ep, cnt, scnt};
    vecs.push_back(r);
  endtask

  // From prev=0 in HUNT: two clean periods 0,1,3,0,1,3,0 with lock on the last 0.
  task automatic addRelock(input logic ctrl, input logic [7:0] cnt, input logic [1:0] scnt);
    addVec(2'd1, 1'b1, 1'b0, ctrl, 1'b0, 1'b0, 1'b0, cnt, scnt);
    addVec(2'd3, 1'b1, 1'b0, ctrl, 1'b0, 1'b0, 1'b0, cnt, scnt);
    addVec(2'd0, 1'b1, 1'b0, ctrl, 1'b0, 1'b0, 1'b0, cnt, scnt);
    addVec(2'd1, 1'b1, 1'b0, ctrl, 1'b0, 1'b0, 1'b0, cnt, scnt);
    addVec(2'd3, 1'b1, 1'b0, ctrl, 1'b0, 1'b0, 1'b0, cnt, scnt);
    addVec(2'd0, 1'b1, 1'b0, ctrl, 1'b0, 1'b1, 1'b0, cnt, scnt);
  endtask

  task automatic applyStimulus(input logic [1:0] y, input logic v, input logic clr);
    @(negedge clk);
    yIn    = y;
    yValid = v;
    errClr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int idx, input logic [13:0] exp);
    logic [17:0] act;
    logic [17:0] want;
    act  = {ctrlOut, ctrlValid, locked, errPulse, errCount,
            satCtrlOut, satCtrlValid, satLocked, satErrPulse, satErrCount};
    want = {exp[13:10], exp[9:2], exp[13:10], exp[1:0]};
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s[%0d] got=%b want=%b", tag, idx, act, want);
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] errCnt[9]  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    logic [1:0] satCnt[9]  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // Lock after two periods, then decode 1->3 and 1->2.
    addVec(2'd0, 1, 0, 0, 0, 0, 0, 8'd0, 2'd0);
    addVec(2'd1, 1, 0, 0, 0, 0, 0, 8'd0, 2'd0);
    addVec(2'd3, 1, 0, 0, 0, 0, 0, 8'd0, 2'd0);
    addVec(2'd0, 1, 0, 0, 0, 0, 0, 8'd0, 2'd0);
    addVec(2'd1, 1, 0, 0, 0, 0, 0, 8'd0, 2'd0);
    addVec(2'd2, 1, 0, 0, 0, 0, 0, 8'd0, 2'd0);
    addVec(2'd3, 1, 0, 0, 0, 0, 0, 8'd0, 2'd0);
    addVec(2'd0, 1, 0, 0, 0, 1, 0, 8'd0, 2'd0);
    addVec(2'd1, 1, 0, 0, 0, 1, 0, 8'd0, 2'd0);
    addVec(2'd3, 1, 0, 1, 1, 1, 0, 8'd0, 2'd0);
    addVec(2'd0, 1, 0, 1, 0, 1, 0, 8'd0, 2'd0);
    addVec(2'd1, 1, 0, 1, 0, 1, 0, 8'd0, 2'd0);
    addVec(2'd2, 1, 0, 0, 1, 1, 0, 8'd0, 2'd0);
    // Locked error 0->2, then hunt with a 1->3 branch that must stay silent.
    addVec(2'd3, 1, 0, 0, 0, 1, 0, 8'd0, 2'd0);
    addVec(2'd0, 1, 0, 0, 0, 1, 0, 8'd0, 2'd0);
    addVec(2'd2, 1, 0, 0, 0, 0, 1, 8'd1, 2'd1);
    addVec(2'd3, 1, 0, 0, 0, 0, 0, 8'd1, 2'd1);
    addVec(2'd0, 1, 0, 0, 0, 0, 0, 8'd1, 2'd1);
    addVec(2'd1, 1, 0, 0, 0, 0, 0, 8'd1, 2'd1);
    addVec(2'd3, 1, 0, 0, 0, 0, 0, 8'd1, 2'd1);
    addVec(2'd0, 1, 0, 0, 0, 1, 0, 8'd1, 2'd1);
    // Valid gaps with garbage on y_in between 1 and 3.
    addVec(2'd1, 1, 0, 0, 0, 1, 0, 8'd1, 2'd1);
    addVec(2'd2, 0, 0, 0, 0, 1, 0, 8'd1, 2'd1);
    addVec(2'd2, 0, 0, 0, 0, 1, 0, 8'd1, 2'd1);
    addVec(2'd2, 0, 0, 0, 0, 1, 0, 8'd1, 2'd1);
    addVec(2'd3, 1, 0, 1, 1, 1, 0, 8'd1, 2'd1);
    addVec(2'd0, 0, 0, 1, 0, 1, 0, 8'd1, 2'd1);
    // 3->3 error, then hunt silence: 0->0, 0->2, 2->1 must clear the period count.
    addVec(2'd3, 1, 0, 1, 0, 0, 1, 8'd2, 2'd2);
    addVec(2'd0, 1, 0, 1, 0, 0, 0, 8'd2, 2'd2);
    addVec(2'd0, 1, 0, 1, 0, 0, 0, 8'd2, 2'd2);
    addVec(2'd2, 1, 0, 1, 0, 0, 0, 8'd2, 2'd2);
    addVec(2'd1, 1, 0, 1, 0, 0, 0, 8'd2, 2'd2);
    addVec(2'd3, 1, 0, 1, 0, 0, 0, 8'd2, 2'd2);
    addVec(2'd0, 1, 0, 1, 0, 0, 0, 8'd2, 2'd2);
    addVec(2'd1, 1, 0, 1, 0, 0, 0, 8'd2, 2'd2);
    addVec(2'd2, 1, 0, 1, 0, 0, 0, 8'd2, 2'd2);
    addVec(2'd3, 1, 0, 1, 0, 0, 0, 8'd2, 2'd2);
    addVec(2'd0, 1, 0, 1, 0, 1, 0, 8'd2, 2'd2);
    // Standalone clear on an idle cycle.
    addVec(2'd0, 0, 1, 1, 0, 1, 0, 8'd0, 2'd0);
    // Nine locked 0->0 errors with relock between; the fifth carries err_clr.
    for (int e = 0; e < 9; e++) begin
      addVec(2'd0, 1, (e == 4), 1, 0, 0, 1, errCnt[e], satCnt[e]);
      addRelock(1'b1, errCnt[e], satCnt[e]);
    end

    reset  = 1'b1;
    yIn    = 2'd0;
    yValid = 1'b0;
    errClr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("resetState", 0, {4'b0000, 8'd0, 2'd0});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].y, vecs[i].v, vecs[i].clr);
      checkOutput("vec", i, vecs[i].exp);
    end

    // Asynchronous reset mid-cycle while locked with err_count=5.
    checkOutput("preReset", 0, {4'b1010, 8'd5, 2'd3});
    #2;
    reset = 1'b1;
    #1;
    checkOutput("asyncReset", 0, {4'b0000, 8'd0, 2'd0});
    @(negedge clk);
    reset  = 1'b0;
    yValid = 1'b0;
    // First sample after reset is not checked; relock then needs two periods.
    applyStimulus(2'd2, 1'b1, 1'b0);
    checkOutput("postReset", 0, {4'b0000, 8'd0, 2'd0});
    applyStimulus(2'd3, 1'b1, 1'b0);
    checkOutput("postReset", 1, {4'b0000, 8'd0, 2'd0});
    applyStimulus(2'd0, 1'b1, 1'b0);
    checkOutput("postReset", 2, {4'b0000, 8'd0, 2'd0});
    applyStimulus(2'd1, 1'b1, 1'b0);
    applyStimulus(2'd3, 1'b1, 1'b0);
    checkOutput("postReset", 3, {4'b0000, 8'd0, 2'd0});
    applyStimulus(2'd0, 1'b1, 1'b0);
    checkOutput("postReset", 4, {4'b0010, 8'd0, 2'd0});
    // Clear and error together on an empty counter still reads back 1.
    applyStimulus(2'd0, 1'b1, 1'b1);
    checkOutput("clrWithErr", 0, {4'b0001, 8'd1, 2'd1});
    applyStimulus(2'd0, 1'b0, 1'b0);
    checkOutput("clrWithErr", 1, {4'b0000, 8'd1, 2'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
